mem_request_unit: RTL and testbench



---
 rtl/mem_request_unit_pkg.sv | 15 +
 rtl/mem_request_unit_sat_counter.sv | 29 ++
 rtl/mem_request_unit.sv | 145 ++++++++++++++
 tb/tb_mem_request_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_request_unit_pkg.sv
// Shared types for the memory request sequencer: request-phase state and helpers.
package mem_request_unit_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } reqstate_t;

   // True when the decoded instruction touches data memory.
   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_request_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;

   // Counter register: clear wins over enable, and the value sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (en && (cnt_r != {W{1'b1}})) begin
         cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/mem_request_unit.sv
// Sequences I-fetch and data requests toward the cache and strobes PC advance.
// Optional watchdog on long data waits is built when REQ_WATCHDOG_EN is defined.
module mem_request_unit
   import mem_request_unit_pkg::*;
#(
   parameter int WAIT_W     = 8
`ifdef REQ_WATCHDOG_EN
   ,
   parameter int WDOG_LIMIT = 64
`endif
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              dREN_in,
   input  logic              dWEN_in,
   input  logic              halt_in,
   output logic              imemREN,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic              pcEN,
   output logic              halt,
`ifdef REQ_WATCHDOG_EN
   output logic [WAIT_W-1:0] dwait_cnt,
   output logic              wdog_err
`else
   output logic [WAIT_W-1:0] dwait_cnt
`endif
);

   reqstate_t         state_r;
   reqstate_t         state_next_s;
   logic              dmem_ren_r;
   logic              dmem_wen_r;
   logic              dmem_ren_next_s;
   logic              dmem_wen_next_s;
   logic              halt_r;
   logic              imem_ren_s;
   logic              pc_en_s;
   logic              cnt_clr_s;
   logic              cnt_en_s;
   logic [WAIT_W-1:0] dwait_cnt_s;

   // State and registered request outputs.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r    <= FETCH;
         dmem_ren_r <= 1'b0;
         dmem_wen_r <= 1'b0;
         halt_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         dmem_ren_r <= dmem_ren_next_s;
         dmem_wen_r <= dmem_wen_next_s;
         halt_r     <= (state_next_s == HALTED);
      end
   end

   // Next-state, request selection and PC strobe.
   always_comb begin
      state_next_s    = state_r;
      dmem_ren_next_s = dmem_ren_r;
      dmem_wen_next_s = dmem_wen_r;
      imem_ren_s      = 1'b0;
      pc_en_s         = 1'b0;
      cnt_clr_s       = 1'b0;
      cnt_en_s        = 1'b0;
      case (state_r)
         FETCH: begin
            imem_ren_s = 1'b1;
            if (!ihit) begin
               state_next_s = FETCH;
            end else if (halt_in) begin
               state_next_s = HALTED;
            end else if (is_mem_op(dREN_in, dWEN_in)) begin
               // A write takes precedence when decode flags both directions.
               state_next_s    = DATA;
               dmem_wen_next_s = dWEN_in;
               dmem_ren_next_s = dREN_in & ~dWEN_in;
               cnt_clr_s       = 1'b1;
            end else begin
               pc_en_s = 1'b1;
            end
         end
         DATA: begin
            if (dhit) begin
               pc_en_s         = 1'b1;
               state_next_s    = FETCH;
               dmem_ren_next_s = 1'b0;
               dmem_wen_next_s = 1'b0;
            end else begin
               cnt_en_s = 1'b1;
            end
         end
         HALTED: begin
            state_next_s    = HALTED;
            dmem_ren_next_s = 1'b0;
            dmem_wen_next_s = 1'b0;
         end
         default: begin
            state_next_s    = FETCH;
            dmem_ren_next_s = 1'b0;
            dmem_wen_next_s = 1'b0;
         end
      endcase
   end

   sat_counter #(
      .W(WAIT_W)
   ) u_dwait (
      .clk  (CLK),
      .rst_n(nRST),
      .clr  (cnt_clr_s),
      .en   (cnt_en_s),
      .cnt  (dwait_cnt_s)
   );

`ifdef REQ_WATCHDOG_EN
   logic wdog_r;
   logic wdog_trip_s;

   assign wdog_trip_s = (state_r == DATA) && !dhit &&
                        (32'(dwait_cnt_s) >= 32'(WDOG_LIMIT - 1));

   // Sticky watchdog flag, cleared only by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wdog_r <= 1'b0;
      end else begin
         wdog_r <= wdog_r | wdog_trip_s;
      end
   end

   assign wdog_err = wdog_r;
`endif

   assign imemREN   = imem_ren_s;
   assign pcEN      = pc_en_s;
   assign dmemREN   = dmem_ren_r;
   assign dmemWEN   = dmem_wen_r;
   assign halt      = halt_r;
   assign dwait_cnt = dwait_cnt_s;

endmodule

// File: tb/tb_mem_request_unit.sv
// Randomized and directed bench for mem_request_unit against a behavioural model.
module tb_mem_request_unit;

   localparam int TB_WAIT_W = 8;
   localparam int TB_WDOG   = 4;
   localparam int MAXC      = (1 << TB_WAIT_W) - 1;

   logic                 CLK = 1'b0;
   logic                 nRST;
   logic                 ihit, dhit, dREN_in, dWEN_in, halt_in;
   logic                 imemREN, dmemREN, dmemWEN, pcEN, halt;
   logic [TB_WAIT_W-1:0] dwait_cnt;
`ifdef REQ_WATCHDOG_EN
   logic                 wdog_err;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: which phase the instruction flow is in.
   bit m_halted, m_data, m_write, m_wdog;
   int m_waits;

   always #5 CLK = ~CLK;

`ifdef REQ_WATCHDOG_EN
   mem_request_unit #(.WAIT_W(TB_WAIT_W), .WDOG_LIMIT(TB_WDOG)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_in(dREN_in),
      .dWEN_in(dWEN_in), .halt_in(halt_in), .imemREN(imemREN), .dmemREN(dmemREN),
      .dmemWEN(dmemWEN), .pcEN(pcEN), .halt(halt), .dwait_cnt(dwait_cnt),
      .wdog_err(wdog_err));
`else
   mem_request_unit #(.WAIT_W(TB_WAIT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_in(dREN_in),
      .dWEN_in(dWEN_in), .halt_in(halt_in), .imemREN(imemREN), .dmemREN(dmemREN),
      .dmemWEN(dmemWEN), .pcEN(pcEN), .halt(halt), .dwait_cnt(dwait_cnt));
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_halted = 1'b0;
      m_data   = 1'b0;
      m_write  = 1'b0;
      m_wdog   = 1'b0;
      m_waits  = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_imemREN"}, 32'(imemREN), 32'd1);
      check_eq({tag, "_dmemREN"}, 32'(dmemREN), 32'd0);
      check_eq({tag, "_dmemWEN"}, 32'(dmemWEN), 32'd0);
      check_eq({tag, "_pcEN"}, 32'(pcEN), 32'd0);
      check_eq({tag, "_halt"}, 32'(halt), 32'd0);
      check_eq({tag, "_dwait"}, 32'(dwait_cnt), 32'd0);
`ifdef REQ_WATCHDOG_EN
      check_eq({tag, "_wdog"}, 32'(wdog_err), 32'd0);
`endif
   endtask

   // Asynchronous reset applied mid-cycle; outputs must drop before any clock edge.
   task automatic do_reset(input string tag);
      ihit = 1'b0; dhit = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
      nRST = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   // One clock of stimulus: check outputs against the model, then advance the model.
   task automatic step(input bit ih, input bit dh, input bit dr, input bit dw, input bit hi);
      bit fetch, exp_pc;
      ihit = ih; dhit = dh; dREN_in = dr; dWEN_in = dw; halt_in = hi;
      @(negedge CLK);
      fetch  = !m_halted && !m_data;
      exp_pc = (fetch && ih && !hi && !dr && !dw) || (m_data && dh);
      check_eq("imemREN", 32'(imemREN), 32'(fetch));
      check_eq("dmemREN", 32'(dmemREN), 32'(m_data && !m_write));
      check_eq("dmemWEN", 32'(dmemWEN), 32'(m_data && m_write));
      check_eq("pcEN", 32'(pcEN), 32'(exp_pc));
      check_eq("halt", 32'(halt), 32'(m_halted));
      check_eq("dwait_cnt", 32'(dwait_cnt), 32'(m_waits));
`ifdef REQ_WATCHDOG_EN
      check_eq("wdog_err", 32'(wdog_err), 32'(m_wdog));
`endif
      if (fetch) begin
         if (ih && hi) begin
            m_halted = 1'b1;
         end else if (ih && (dr || dw)) begin
            m_data  = 1'b1;
            m_write = dw;
            m_waits = 0;
         end
      end else if (m_data) begin
         if (dh) begin
            m_data = 1'b0;
         end else begin
            if (m_waits >= TB_WDOG - 1) m_wdog = 1'b1;
            if (m_waits < MAXC) m_waits++;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      ihit = 1'b0; dhit = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
      nRST = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_reset_outputs("por");
      nRST = 1'b1;

      // ALU instructions: one pcEN per ihit.
      repeat (3) step(1, 0, 0, 0, 0);

      // LW with five wait cycles.
      step(1, 0, 1, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0);
      check_eq("lw_wait5", 32'(dwait_cnt), 32'd5);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // SW flagged as both read and write; dhit coincides with ihit.
      step(1, 0, 1, 1, 0);
      check_eq("sw_wen", 32'(dmemWEN), 32'd1);
      check_eq("sw_ren", 32'(dmemREN), 32'd0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // HALT wins over a write; stays halted under input toggling.
      step(1, 0, 0, 1, 1);
      check_eq("halted_flag", 32'(halt), 32'd1);
      for (int i = 0; i < 10; i++) step(i[0], ~i[0], i[1], 0, 0);
      do_reset("halt_rst");

      // Reset mid-DATA after three waits.
      step(1, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      check_eq("pre_rst_wait3", 32'(dwait_cnt), 32'd3);
      do_reset("data_rst");
      step(1, 0, 0, 0, 0);

      // Long wait: counter saturates; any watchdog stays set after dhit.
      step(1, 0, 1, 0, 0);
      repeat (MAXC + 5) step(0, 0, 0, 0, 0);
      check_eq("sat_max", 32'(dwait_cnt), 32'(MAXC));
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
`ifdef REQ_WATCHDOG_EN
      check_eq("wdog_sticky", 32'(wdog_err), 32'd1);
`endif
      do_reset("pre_rand");

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset("rand_rst");
         end else begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 3);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
